// File: rtl/uart_tx_scheduler_if.sv
// Request/grant and transmitter-drive bundle for uart_tx_scheduler.
// master = byte producers / transmitter side, slave = the scheduler.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_en;
  logic [7:0]           tx_data;
  logic                 busy;
  logic [IDW-1:0]       grant_id;

  modport master (output req, req_data, input ack, tx_en, tx_data, busy, grant_id);
  modport slave  (input req, req_data, output ack, tx_en, tx_data, busy, grant_id);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin share of one UART byte transmitter; ack and first tx_en one cycle after req is seen in IDLE.
// The transmitter gives no backpressure, so every strobe is followed by a fixed GAP_CYCLES idle window.
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int BPS_PARA   = 1250,
  parameter int GAP_CYCLES = 11 * BPS_PARA,
  parameter bit FRAME_EN   = 1'b1,
  parameter int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_tx_scheduler_if.slave io_bus
);

  localparam int CW = 17;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR_STB, S_HDR_GAP, S_DAT_STB, S_DAT_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [IDW-1:0]     r_last, r_grant_id, w_win_id, w_idx;
  logic               w_win_vld, w_grant;
  logic [7:0]         r_payload, r_tx_data, w_tx_data_nxt, w_req_byte;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic               r_tx_en, w_tx_en_nxt, r_busy;

  // Search starts one past the last winner and wraps, giving the rotation order.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_idx     = r_last;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + IDW'(1);
      if (!w_win_vld && io_bus.req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = w_idx;
      end
    end
  end

  always_comb begin
    w_req_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_id == IDW'(i)) w_req_byte = io_bus.req_data[8*i +: 8];
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_win_vld;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= IDW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_payload  <= '0;
      r_ack      <= '0;
      r_tx_en    <= 1'b0;
      r_tx_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ack     <= w_ack_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_last     <= w_win_id;
        r_grant_id <= w_win_id;
        r_payload  <= w_req_byte;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE:    if (w_win_vld) w_state_nxt = FRAME_EN ? S_HDR_STB : S_DAT_STB;
      S_HDR_STB: begin
        w_state_nxt = S_HDR_GAP;
        w_cnt_nxt   = GAP_LOAD;
      end
      S_HDR_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_DAT_STB;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_DAT_STB: begin
        w_state_nxt = S_DAT_GAP;
        w_cnt_nxt   = GAP_LOAD;
      end
      S_DAT_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // tx_data only moves on the cycle before a strobe, so it is stable across each gap.
  always_comb begin
    w_ack_nxt     = '0;
    w_tx_data_nxt = r_tx_data;
    if (w_grant) begin
      w_ack_nxt     = NUM_REQ'(1) << w_win_id;
      w_tx_data_nxt = FRAME_EN ? {4'hA, 4'(w_win_id)} : w_req_byte;
    end else if (r_state == S_HDR_GAP && r_cnt == '0) begin
      w_tx_data_nxt = r_payload;
    end
    w_tx_en_nxt = (w_state_nxt == S_HDR_STB) || (w_state_nxt == S_DAT_STB);
  end

  assign io_bus.ack      = r_ack;
  assign io_bus.tx_en    = r_tx_en;
  assign io_bus.tx_data  = r_tx_data;
  assign io_bus.busy     = r_busy;
  assign io_bus.grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomised checks of uart_tx_scheduler with a shortened bit period (GAP = 33 cycles);
// one instance with header framing, one payload-only.
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int BPS = 3;
  localparam int GAP = 11 * BPS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_scheduler_if #(.NUM_REQ(N)) bf ();
  uart_tx_scheduler_if #(.NUM_REQ(N)) bp ();

  uart_tx_scheduler #(.NUM_REQ(N), .BPS_PARA(BPS), .FRAME_EN(1'b1)) dut_f (
    .i_clk(clk), .i_rst(rst), .io_bus(bf));
  uart_tx_scheduler #(.NUM_REQ(N), .BPS_PARA(BPS), .FRAME_EN(1'b0)) dut_p (
    .i_clk(clk), .i_rst(rst), .io_bus(bp));

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_tx(input bit sel_p, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((sel_p ? bp.tx_en : bf.tx_en) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input bit sel_p, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((sel_p ? bp.busy : bf.busy) === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    bf.req = '0; bf.req_data = '0;
    bp.req = '0; bp.req_data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bf.ack, bf.tx_en, bf.tx_data, bf.busy, bf.grant_id} !== '0)
      begin n_err++; $display("FAIL reset_f: got ack=%b en=%b dat=%h busy=%b id=%0d expected all 0", bf.ack, bf.tx_en, bf.tx_data, bf.busy, bf.grant_id); end
    n_vec++;
    if ({bp.ack, bp.tx_en, bp.tx_data, bp.busy, bp.grant_id} !== '0)
      begin n_err++; $display("FAIL reset_p: got ack=%b en=%b dat=%h busy=%b id=%0d expected all 0", bp.ack, bp.tx_en, bp.tx_data, bp.busy, bp.grant_id); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bf.busy !== 1'b0 || bf.tx_en !== 1'b0)
      begin n_err++; $display("FAIL idle_no_req: got busy=%b en=%b expected 0 0", bf.busy, bf.tx_en); end
  endtask

  task automatic test_single;
    bit ok;
    int t0;
    bf.req_data[7:0] = 8'h5A;
    bf.req = 4'b0001;
    @(negedge clk);
    n_vec++; if (bf.ack !== 4'b0001) begin n_err++; $display("FAIL single_ack: got %b expected 0001", bf.ack); end
    n_vec++; if (bf.tx_en !== 1'b1) begin n_err++; $display("FAIL single_hdr_en: got %b expected 1", bf.tx_en); end
    n_vec++; if (bf.tx_data !== 8'hA0) begin n_err++; $display("FAIL single_hdr: got %h expected a0", bf.tx_data); end
    n_vec++; if (bf.busy !== 1'b1 || bf.grant_id !== 2'd0) begin n_err++; $display("FAIL single_busy_id: got %b %0d expected 1 0", bf.busy, bf.grant_id); end
    t0 = cyc;
    bf.req = '0;
    @(negedge clk);
    n_vec++;
    if (bf.ack !== 4'b0000 || bf.tx_en !== 1'b0 || bf.tx_data !== 8'hA0)
      begin n_err++; $display("FAIL single_pulse: got ack=%b en=%b dat=%h expected 0000 0 a0", bf.ack, bf.tx_en, bf.tx_data); end
    wait_tx(1'b0, GAP + 5, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_pay_timeout: got none expected strobe"); end
    n_vec++; if (cyc - t0 !== GAP + 1) begin n_err++; $display("FAIL single_spacing: got %0d expected %0d", cyc - t0, GAP + 1); end
    n_vec++; if (bf.tx_data !== 8'h5A) begin n_err++; $display("FAIL single_pay: got %h expected 5a", bf.tx_data); end
    repeat (GAP) @(negedge clk);
    n_vec++; if (bf.busy !== 1'b1 || bf.tx_data !== 8'h5A) begin n_err++; $display("FAIL single_gap_end: got busy=%b dat=%h expected 1 5a", bf.busy, bf.tx_data); end
    @(negedge clk);
    n_vec++; if (bf.busy !== 1'b0) begin n_err++; $display("FAIL single_done: got busy=%b expected 0", bf.busy); end
  endtask

  task automatic test_round_robin;
    bit ok;
    int th, tp;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bf.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bf.req = 4'b1111;
    tp = 0;
    for (int g = 0; g < 5; g++) begin
      int id;
      id = g % N;
      wait_tx(1'b0, 2 * GAP + 10, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rr_hdr_timeout g%0d: got none expected strobe", g); end
      n_vec++; if (bf.tx_data !== (8'hA0 | 8'(id))) begin n_err++; $display("FAIL rr_hdr g%0d: got %h expected %h", g, bf.tx_data, 8'hA0 | 8'(id)); end
      n_vec++; if (bf.ack !== (4'b0001 << id) || bf.grant_id !== 2'(id)) begin n_err++; $display("FAIL rr_ack g%0d: got %b id %0d expected %b id %0d", g, bf.ack, bf.grant_id, 4'b0001 << id, id); end
      if (g > 0) begin
        n_vec++; if (cyc - tp !== GAP + 2) begin n_err++; $display("FAIL rr_pair_gap g%0d: got %0d expected %0d", g, cyc - tp, GAP + 2); end
      end
      th = cyc;
      if (g == 4) bf.req = '0;
      wait_tx(1'b0, GAP + 5, ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL rr_pay_timeout g%0d: got none expected strobe", g); end
      n_vec++; if (bf.tx_data !== 8'h10 + 8'(id)) begin n_err++; $display("FAIL rr_pay g%0d: got %h expected %h", g, bf.tx_data, 8'h10 + 8'(id)); end
      n_vec++; if (cyc - th !== GAP + 1) begin n_err++; $display("FAIL rr_spacing g%0d: got %0d expected %0d", g, cyc - th, GAP + 1); end
      tp = cyc;
    end
    wait_idle(1'b0, GAP + 5, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rr_idle_timeout: got busy expected idle"); end
  endtask

  task automatic test_late_req;
    int n_stb;
    bp.req_data = {8'h00, 8'h92, 8'h71, 8'h00};
    bp.req = 4'b0010;
    @(negedge clk);
    n_vec++;
    if (bp.ack !== 4'b0010 || bp.tx_en !== 1'b1 || bp.tx_data !== 8'h71 || bp.grant_id !== 2'd1)
      begin n_err++; $display("FAIL late_first: got ack=%b en=%b dat=%h id=%0d expected 0010 1 71 1", bp.ack, bp.tx_en, bp.tx_data, bp.grant_id); end
    bp.req = '0;
    repeat (GAP - 5) @(negedge clk);
    bp.req = 4'b0100;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (bp.ack !== 4'b0000 || bp.tx_en !== 1'b0 || bp.busy !== (i < 6))
        begin n_err++; $display("FAIL late_wait c%0d: got ack=%b en=%b busy=%b expected 0000 0 %b", i, bp.ack, bp.tx_en, bp.busy, i < 6); end
    end
    @(negedge clk);
    n_vec++;
    if (bp.ack !== 4'b0100 || bp.tx_en !== 1'b1 || bp.tx_data !== 8'h92 || bp.grant_id !== 2'd2)
      begin n_err++; $display("FAIL late_grant: got ack=%b en=%b dat=%h id=%0d expected 0100 1 92 2", bp.ack, bp.tx_en, bp.tx_data, bp.grant_id); end
    bp.req = '0;
    n_stb = 0;
    repeat (GAP + 1) begin
      @(negedge clk);
      if (bp.tx_en === 1'b1) n_stb++;
    end
    n_vec++; if (n_stb !== 0) begin n_err++; $display("FAIL late_single: got %0d extra strobes expected 0", n_stb); end
    n_vec++; if (bp.busy !== 1'b0) begin n_err++; $display("FAIL late_done: got busy=%b expected 0", bp.busy); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int th;
    bf.req_data[31:24] = 8'hC3;
    bf.req = 4'b1000;
    @(negedge clk);
    n_vec++; if (bf.ack !== 4'b1000 || bf.tx_en !== 1'b1) begin n_err++; $display("FAIL mid_first: got ack=%b en=%b expected 1000 1", bf.ack, bf.tx_en); end
    repeat (5) @(negedge clk);
    n_vec++; if (bf.busy !== 1'b1 || bf.ack !== 4'b0000) begin n_err++; $display("FAIL mid_gap: got busy=%b ack=%b expected 1 0000", bf.busy, bf.ack); end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bf.ack, bf.tx_en, bf.tx_data, bf.busy, bf.grant_id} !== '0)
      begin n_err++; $display("FAIL mid_reset: got ack=%b en=%b dat=%h busy=%b id=%0d expected all 0", bf.ack, bf.tx_en, bf.tx_data, bf.busy, bf.grant_id); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bf.ack !== 4'b1000 || bf.tx_en !== 1'b1 || bf.tx_data !== 8'hA3 || bf.grant_id !== 2'd3)
      begin n_err++; $display("FAIL mid_regrant: got ack=%b en=%b dat=%h id=%0d expected 1000 1 a3 3", bf.ack, bf.tx_en, bf.tx_data, bf.grant_id); end
    th = cyc;
    bf.req = '0;
    wait_tx(1'b0, GAP + 5, ok);
    n_vec++; if (!ok || bf.tx_data !== 8'hC3 || cyc - th !== GAP + 1)
      begin n_err++; $display("FAIL mid_pay: got ok=%b dat=%h dt=%0d expected 1 c3 %0d", ok, bf.tx_data, cyc - th, GAP + 1); end
    wait_idle(1'b0, GAP + 5, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_idle_timeout: got busy expected idle"); end
  endtask

  task automatic test_bus_check;
    logic [7:0] q[$];
    logic [7:0] d[N];
    logic [7:0] pat, exp_b, prev_dat;
    bit prev_en;
    int p, wait_c, guard;
    p = 0; wait_c = 0; guard = 0;
    prev_en = 1'b0;
    prev_dat = bf.tx_data;
    while ((p < 1000 || bf.req != '0 || bf.busy === 1'b1) && guard < 20000) begin
      if (p < 1000 && wait_c <= 0) begin
        pat = 8'($urandom);
        for (int i = 0; i < N; i++) begin
          if (pat[i] && !bf.req[i]) begin
            d[i] = 8'($urandom);
            bf.req_data[8*i +: 8] = d[i];
            bf.req[i] = 1'b1;
          end
        end
        p++;
        wait_c = $urandom_range(1, 4);
      end
      @(negedge clk);
      guard++;
      wait_c--;
      n_vec++; if ($countones(bf.ack) > 1) begin n_err++; $display("FAIL bus_ack_onehot: got %b expected at most one bit", bf.ack); end
      n_vec++; if (prev_en && bf.tx_en === 1'b1) begin n_err++; $display("FAIL bus_en_double: got two strobes in a row expected one"); end
      if (bf.tx_en !== 1'b1) begin
        n_vec++; if (bf.tx_data !== prev_dat) begin n_err++; $display("FAIL bus_data_hold: got %h expected %h", bf.tx_data, prev_dat); end
      end
      for (int i = 0; i < N; i++) begin
        if (bf.ack[i] === 1'b1) begin
          q.push_back(8'hA0 | 8'(i));
          q.push_back(d[i]);
          bf.req[i] = 1'b0;
        end
      end
      if (bf.tx_en === 1'b1) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL bus_spurious: got strobe with %h expected none", bf.tx_data);
        end else begin
          exp_b = q.pop_front();
          if (bf.tx_data !== exp_b) begin n_err++; $display("FAIL bus_byte: got %h expected %h", bf.tx_data, exp_b); end
        end
      end
      prev_en = (bf.tx_en === 1'b1);
      prev_dat = bf.tx_data;
    end
    n_vec++; if (guard >= 20000) begin n_err++; $display("FAIL bus_timeout: got %0d cycles expected drain", guard); end
    n_vec++; if (q.size() != 0) begin n_err++; $display("FAIL bus_lost: got %0d bytes unsent expected 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_late_req();
    test_reset_mid();
    test_bus_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
